// File: rtl/popcount_tern_seq.sv
// Sequential ternary-neuron popcount: counts W bits of each polarity per cycle,
// then registers the counts, their signed difference and a thresholded decision.
module popcount_tern_seq #(
  parameter int N  = 25,
  parameter int W  = 5,
  parameter int CW = $clog2(N + 1),
  parameter int S  = (N + W - 1) / W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_pos,
  input  logic [N-1:0]  in_neg,
  input  logic [CW:0]   thr_hi,
  input  logic [CW:0]   thr_lo,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_cnt_pos,
  output logic [CW-1:0] out_cnt_neg,
  output logic [CW:0]   out_diff,
  output logic [1:0]    out_tern,
  output logic [1:0]    dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never drops and the data never changes until that edge.

  localparam int KW = (S > 1) ? $clog2(S) : 1;
  localparam int SW = S * W;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [CW-1:0] pop_slice(input logic [W-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  state_t        state_q;
  logic          in_ready_q, out_valid_q;
  logic [SW-1:0] pos_q, neg_q, pos_ext, neg_ext;
  logic [CW:0]   thr_hi_q, thr_lo_q;
  logic [KW-1:0] k_q;
  logic [CW-1:0] acc_pos_q, acc_neg_q, sum_pos_d, sum_neg_d;
  logic [CW-1:0] cnt_pos_q, cnt_neg_q;
  logic [CW:0]   diff_q, diff_d;
  logic [1:0]    tern_q, tern_d;
  logic [W-1:0]  slice_pos, slice_neg;
  logic          last_slice;

  // Operands are zero-padded to whole slices so the last slice counts padding as 0.
  always_comb begin
    pos_ext = '0;
    neg_ext = '0;
    pos_ext[N-1:0] = in_pos;
    neg_ext[N-1:0] = in_neg;
    slice_pos  = pos_q[k_q * W +: W];
    slice_neg  = neg_q[k_q * W +: W];
    last_slice = (k_q == KW'(S - 1));
    sum_pos_d  = acc_pos_q + pop_slice(slice_pos);
    sum_neg_d  = acc_neg_q + pop_slice(slice_neg);
    diff_d     = {1'b0, sum_pos_d} - {1'b0, sum_neg_d};
    tern_d     = 2'b00;
    if ($signed(diff_d) >= $signed(thr_hi_q))      tern_d = 2'b01;
    else if ($signed(diff_d) <= $signed(thr_lo_q)) tern_d = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      pos_q       <= '0;
      neg_q       <= '0;
      thr_hi_q    <= '0;
      thr_lo_q    <= '0;
      k_q         <= '0;
      acc_pos_q   <= '0;
      acc_neg_q   <= '0;
      cnt_pos_q   <= '0;
      cnt_neg_q   <= '0;
      diff_q      <= '0;
      tern_q      <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            pos_q      <= pos_ext;
            neg_q      <= neg_ext;
            thr_hi_q   <= thr_hi;
            thr_lo_q   <= thr_lo;
            acc_pos_q  <= '0;
            acc_neg_q  <= '0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          acc_pos_q <= sum_pos_d;
          acc_neg_q <= sum_neg_d;
          if (last_slice) begin
            cnt_pos_q   <= sum_pos_d;
            cnt_neg_q   <= sum_neg_d;
            diff_q      <= diff_d;
            tern_q      <= tern_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_cnt_pos = cnt_pos_q;
  assign out_cnt_neg = cnt_neg_q;
  assign out_diff    = diff_q;
  assign out_tern    = tern_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_popcount_tern_seq.sv
// Bench for popcount_tern_seq: default build (N=25,W=5), a single-slice build
// (N=25,W=25) sharing its inputs, and a padded build (N=7,W=3).
module tb_popcount_tern_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready;
  logic [24:0] in_pos, in_neg;
  logic [5:0]  thr_hi, thr_lo;
  logic        in_ready, out_valid;
  logic [4:0]  cnt_pos, cnt_neg;
  logic [5:0]  diff;
  logic [1:0]  tern, dbg;

  logic        s_in_ready, s_out_valid;
  logic [4:0]  s_cnt_pos, s_cnt_neg;
  logic [5:0]  s_diff;
  logic [1:0]  s_tern, s_dbg;

  logic        d1_in_valid, d1_out_ready, d1_in_ready, d1_out_valid;
  logic [6:0]  d1_in_pos, d1_in_neg;
  logic [3:0]  d1_thr_hi, d1_thr_lo, d1_diff;
  logic [2:0]  d1_cnt_pos, d1_cnt_neg;
  logic [1:0]  d1_tern, d1_dbg;

  popcount_tern_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_neg(in_neg), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .out_valid(out_valid), .out_ready(out_ready), .out_cnt_pos(cnt_pos),
    .out_cnt_neg(cnt_neg), .out_diff(diff), .out_tern(tern), .dbg_state_o(dbg));

  popcount_tern_seq #(.N(25), .W(25)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_pos(in_pos), .in_neg(in_neg), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_cnt_pos(s_cnt_pos),
    .out_cnt_neg(s_cnt_neg), .out_diff(s_diff), .out_tern(s_tern), .dbg_state_o(s_dbg));

  popcount_tern_seq #(.N(7), .W(3)) dut_n7 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .in_pos(d1_in_pos), .in_neg(d1_in_neg), .thr_hi(d1_thr_hi), .thr_lo(d1_thr_lo),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_cnt_pos(d1_cnt_pos),
    .out_cnt_neg(d1_cnt_neg), .out_diff(d1_diff), .out_tern(d1_tern), .dbg_state_o(d1_dbg));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: counts and ternary decision straight from the arithmetic rule.
  task automatic model(input logic [31:0] p, input logic [31:0] n, input int np,
                       input int hi, input int lo,
                       output int cp, output int cn, output int d, output logic [1:0] t);
    cp = 0;
    cn = 0;
    for (int i = 0; i < np; i++) begin
      cp += int'(p[i]);
      cn += int'(n[i]);
    end
    d = cp - cn;
    if (d >= hi)      t = 2'b01;
    else if (d <= lo) t = 2'b11;
    else              t = 2'b00;
  endtask

  // ---------------- driver for the default and single-slice builds ----------------
  task automatic do_op(input logic [24:0] p, input logic [24:0] n, input int hi, input int lo,
                       input int ecp, input int ecn, input int ed, input logic [1:0] et,
                       input int bp, input bit early, input bit tog, input string tag);
    int lat;
    logic [17:0] rec, held;
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, " in_ready_before"}, 32'(in_ready), 1);
    in_pos = p; in_neg = n; thr_hi = 6'(hi); thr_lo = 6'(lo);
    in_valid = 1'b1;
    out_ready = early;
    exp_q.push_back({5'(ecp), 5'(ecn), 6'(ed), et});
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (tog) begin
        in_pos = 25'($urandom); in_neg = 25'($urandom); thr_hi = 6'($urandom);
      end
      @(posedge clk); #1; lat++;
      if (lat == 1) begin
        check({tag, " s1_valid"}, 32'(s_out_valid), 1);
        check({tag, " s1_cnt_pos"}, 32'(s_cnt_pos), ecp);
        check({tag, " s1_cnt_neg"}, 32'(s_cnt_neg), ecn);
        check({tag, " s1_diff"}, 32'($signed(s_diff)), ed);
        check({tag, " s1_tern"}, 32'(s_tern), 32'(et));
      end
    end
    check({tag, " latency"}, lat, 5);
    if (exp_q.size() > 0) begin
      rec = exp_q.pop_front();
      check({tag, " cnt_pos"}, 32'(cnt_pos), 32'(rec[17:13]));
      check({tag, " cnt_neg"}, 32'(cnt_neg), 32'(rec[12:8]));
      check({tag, " diff"}, 32'($signed(diff)), 32'($signed(rec[7:2])));
      check({tag, " tern"}, 32'(tern), 32'(rec[1:0]));
    end
    held = {cnt_pos, cnt_neg, diff, tern};
    if (!early) begin
      for (int i = 0; i < bp; i++) begin
        @(posedge clk); #1;
        check({tag, " hold_valid"}, 32'(out_valid), 1);
        check({tag, " hold_in_ready"}, 32'(in_ready), 0);
        check({tag, " hold_data"}, 32'({cnt_pos, cnt_neg, diff, tern}), 32'(held));
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid_after_consume"}, 32'(out_valid), 0);
    check({tag, " in_ready_after_consume"}, 32'(in_ready), 1);
  endtask

  typedef struct {
    logic [24:0] p, n;
    int hi, lo, cp, cn, d;
    logic [1:0] t;
    string name;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cp, cn, d, hi, lo, lat;
    logic [1:0] t;
    logic [24:0] p, n;

    vecs[0] = '{25'h1FFFFFF, 25'h0,       5,  -5, 25, 0,  25, 2'b01, "full_scale"};
    vecs[1] = '{25'h0000155, 25'h1F00000, 2,  -1, 5,  5,  0,  2'b00, "mixed_eq"};
    vecs[2] = '{25'h0000055, 25'h1F00000, 2,  -1, 4,  5,  -1, 2'b11, "mixed_lo1"};
    vecs[3] = '{25'h0000055, 25'h1F00000, 2,  -2, 4,  5,  -1, 2'b00, "mixed_lo2"};
    vecs[4] = '{25'h0,       25'h0,       0,  3,  0,  0,  0,  2'b01, "hi_priority"};
    vecs[5] = '{25'h0,       25'h1FFFFFF, 0, -25, 0,  25, -25, 2'b11, "full_neg"};

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_pos = 25'h1FFFFFF; in_neg = '0; thr_hi = '0; thr_lo = '0;
    d1_in_valid = 1'b0; d1_out_ready = 1'b0;
    d1_in_pos = '0; d1_in_neg = '0; d1_thr_hi = '0; d1_thr_lo = '0;

    // reset held for 3 cycles with in_valid high
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst in_ready", 32'(in_ready), 0);
      check("rst out_valid", 32'(out_valid), 0);
      check("rst out_tern", 32'(tern), 0);
    end
    check("rst dbg_state", 32'(dbg), 0);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("rel in_ready", 32'(in_ready), 1);
    check("rel out_valid", 32'(out_valid), 0);

    foreach (vecs[i])
      do_op(vecs[i].p, vecs[i].n, vecs[i].hi, vecs[i].lo, vecs[i].cp, vecs[i].cn,
            vecs[i].d, vecs[i].t, (i == 2) ? 10 : 0, 1'b0, 1'b0, vecs[i].name);

    // early out_ready plus input toggling during RUN
    do_op(25'h0ABCDEF, 25'h1234567, 1, -1, 17, 12, 5, 2'b01, 0, 1'b1, 1'b1, "toggle_early");

    // reset abort at RUN slice 2
    in_pos = 25'h1FFFFFF; in_neg = '0; thr_hi = 6'd1; thr_lo = 6'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort dbg_state", 32'(dbg), 0);
    check("abort in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("abort no_valid", 32'(out_valid), 0);
    end
    check("abort in_ready_back", 32'(in_ready), 1);
    do_op(25'h000000F, 25'h00000F0, 0, -1, 4, 4, 0, 2'b01, 0, 1'b0, 1'b0, "after_abort");

    // randomized against the reference model
    for (int i = 0; i < 25; i++) begin
      p = 25'($urandom); n = 25'($urandom);
      if (i % 5 == 0) n = p >> $urandom_range(0, 3);
      hi = $urandom_range(0, 52) - 26;
      lo = $urandom_range(0, 52) - 26;
      model(32'(p), 32'(n), 25, hi, lo, cp, cn, d, t);
      do_op(p, n, hi, lo, cp, cn, d, t, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), "rand");
    end

    // padded build N=7, W=3: hand case then a few random ones
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        d1_in_pos = 7'b1111111; d1_in_neg = 7'b1000001; hi = 0; lo = 0;
      end else begin
        d1_in_pos = 7'($urandom); d1_in_neg = 7'($urandom);
        hi = $urandom_range(0, 14) - 7; lo = $urandom_range(0, 14) - 7;
      end
      model(32'(d1_in_pos), 32'(d1_in_neg), 7, hi, lo, cp, cn, d, t);
      if (i == 0) begin
        check("n7 model_pos", cp, 7);
        check("n7 model_diff", d, 5);
      end
      d1_thr_hi = 4'(hi); d1_thr_lo = 4'(lo);
      check("n7 in_ready", 32'(d1_in_ready), 1);
      d1_in_valid = 1'b1;
      @(posedge clk); #1;
      d1_in_valid = 1'b0;
      d1_in_pos = 7'($urandom);
      lat = 0;
      while (!d1_out_valid && lat < 50) begin
        @(posedge clk); #1; lat++;
      end
      check("n7 latency", lat, 3);
      check("n7 cnt_pos", 32'(d1_cnt_pos), cp);
      check("n7 cnt_neg", 32'(d1_cnt_neg), cn);
      check("n7 diff", 32'($signed(d1_diff)), d);
      check("n7 tern", 32'(d1_tern), 32'(t));
      d1_out_ready = 1'b1;
      @(posedge clk); #1;
      d1_out_ready = 1'b0;
      check("n7 consumed", 32'(d1_out_valid), 0);
    end

    check("scoreboard empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
